// File: rtl/usr_nbit_seq.sv
// Universal N-bit shift/rotate register with a single-op path and a
// multi-cycle "shift by N" sequencer reporting busy/done.
module usr_nbit_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_r_in,
  input  logic             ser_l_in,
  input  logic             start,
  input  logic [CW-1:0]    shamt,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        mode_reg;
  logic [CW-1:0]     count_reg;

  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (m)
      3'b000: res = cur;
      3'b001: res = {sr, cur[WIDTH-1:1]};
      3'b010: res = {cur[WIDTH-2:0], sl};
      3'b011: res = din;
      3'b100: res = {cur[0], cur[WIDTH-1:1]};
      3'b101: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110: res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Only these modes make sense to repeat; anything else completes at once.
  function automatic logic is_shift(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
           (m == 3'b101) || (m == 3'b110);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count_reg <= '0;
      mode_reg  <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          // Serial inputs are sampled live on every step of the sequence.
          q         <= step(mode_reg, q, d_in, ser_r_in, ser_l_in);
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            mode_reg  <= select;
            count_reg <= shamt;
            if (shamt == '0 || !is_shift(select)) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else if (en) begin
            q <= step(select, q, d_in, ser_r_in, ser_l_in);
          end
        end
      endcase
    end
  end

  assign so_msb = q[WIDTH-1];
  assign so_lsb = q[0];

endmodule

// File: tb/tb_usr_nbit_seq.sv
// Directed self-checking bench for usr_nbit_seq (WIDTH=8).
module tb_usr_nbit_seq;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       select;
  logic [WIDTH-1:0] d_in;
  logic             ser_r_in;
  logic             ser_l_in;
  logic             start;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] q;
  logic             so_msb;
  logic             so_lsb;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  usr_nbit_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .select(select), .d_in(d_in),
    .ser_r_in(ser_r_in), .ser_l_in(ser_l_in), .start(start), .shamt(shamt),
    .q(q), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs can be sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle operation through the en path.
  task automatic op(input logic [2:0] sel, input logic [WIDTH-1:0] d);
    select = sel; d_in = d; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; select = 3'b000; d_in = '0;
    ser_r_in = 1'b0; ser_l_in = 1'b0; start = 1'b0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h busy=%b done=%b required q=00 busy=0 done=0", q, busy, done);
    end
    #3 rst = 1'b0;
    $display("reset: q=%h busy=%b done=%b", q, busy, done);
  endtask

  task automatic test_load_hold();
    op(3'b011, 8'hA5);
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL load: q=%h required a5", q); end
    checks++;
    if (so_msb !== 1'b1 || so_lsb !== 1'b1) begin
      errors++; $display("FAIL serial_out_a5: msb=%b lsb=%b required 1 1", so_msb, so_lsb);
    end
    select = 3'b000; en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL hold: q=%h required a5", q); end
    $display("load/hold: q=%h", q);
  endtask

  task automatic test_shift();
    ser_r_in = 1'b1;
    op(3'b001, 8'h00);
    checks++;
    if (q !== 8'hD2) begin errors++; $display("FAIL shift_right: q=%h required d2", q); end
    ser_r_in = 1'b0;
    op(3'b011, 8'hA5);
    ser_l_in = 1'b0;
    op(3'b010, 8'h00);
    checks++;
    if (q !== 8'h4A) begin errors++; $display("FAIL shift_left: q=%h required 4a", q); end
    checks++;
    if (so_msb !== 1'b0 || so_lsb !== 1'b0) begin
      errors++; $display("FAIL serial_out_4a: msb=%b lsb=%b required 0 0", so_msb, so_lsb);
    end
    select = 3'b010; en = 1'b0;
    repeat (2) tick();
    checks++;
    if (q !== 8'h4A) begin errors++; $display("FAIL en_low_hold: q=%h required 4a", q); end
    $display("shift: q=%h", q);
  endtask

  task automatic test_rotate_asr_clear();
    op(3'b011, 8'hA5); op(3'b101, 8'h00);
    checks++;
    if (q !== 8'h4B) begin errors++; $display("FAIL rotate_left: q=%h required 4b", q); end
    op(3'b011, 8'hA5); op(3'b100, 8'h00);
    checks++;
    if (q !== 8'hD2) begin errors++; $display("FAIL rotate_right: q=%h required d2", q); end
    op(3'b011, 8'hA5); op(3'b110, 8'h00);
    checks++;
    if (q !== 8'hD2) begin errors++; $display("FAIL asr_neg: q=%h required d2", q); end
    op(3'b011, 8'h5A); op(3'b110, 8'h00);
    checks++;
    if (q !== 8'h2D) begin errors++; $display("FAIL asr_pos: q=%h required 2d", q); end
    op(3'b111, 8'hFF);
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL clear: q=%h required 00", q); end
    $display("rotate/asr/clear: q=%h", q);
  endtask

  task automatic test_seq();
    logic [WIDTH-1:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    op(3'b011, 8'h81);
    start = 1'b1; select = 3'b101; shamt = CW'(3);
    tick();
    checks++;
    if (busy !== 1'b1 || q !== 8'h81 || done !== 1'b0) begin
      errors++; $display("FAIL seq_launch: busy=%b q=%h done=%b required 1 81 0", busy, q, done);
    end
    start = 1'b0; en = 1'b1; select = 3'b011; d_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      select = (i == 0) ? 3'b111 : 3'b000;
      checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
        errors++;
        $display("FAIL seq_step%0d: q=%h busy=%b done=%b required %h %b %b",
                 i, q, busy, done, exp_q[i], (i < 2), (i == 2));
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || q !== 8'h0C) begin
      errors++; $display("FAIL seq_done_width: done=%b q=%h required 0 0c", done, q);
    end
    $display("seq rotl x3: q=%h", q);
  endtask

  task automatic test_trivial_start();
    start = 1'b1; select = 3'b001; shamt = '0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C) begin
      errors++; $display("FAIL shamt0: done=%b busy=%b q=%h required 1 0 0c", done, busy, q);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL shamt0_pulse: done=%b required 0", done); end
    start = 1'b1; select = 3'b011; shamt = CW'(4); d_in = 8'h00;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C) begin
      errors++; $display("FAIL nonshift_start: done=%b busy=%b q=%h required 1 0 0c", done, busy, q);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nonshift_after: done=%b busy=%b required 0 0", done, busy);
    end
    $display("trivial starts: q=%h", q);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; select = 3'b101; shamt = CW'(1);
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (q !== 8'h18 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first: q=%h done=%b busy=%b required 18 1 0", q, done, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h30 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_second: q=%h done=%b required 30 1", q, done);
    end
    tick();
    $display("back-to-back: q=%h", q);
  endtask

  task automatic test_busy_ignore();
    int pulses;
    pulses = 0;
    ser_l_in = 1'b0;
    start = 1'b1; select = 3'b010; shamt = CW'(3);
    tick();
    select = 3'b111; shamt = CW'(2);
    tick();
    start = 1'b0;
    checks++;
    if (q !== 8'h60) begin errors++; $display("FAIL ignore_step: q=%h required 60", q); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || q !== 8'h80 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_start: pulses=%0d q=%h busy=%b required 1 80 0", pulses, q, busy);
    end
    $display("start during busy: pulses=%0d q=%h", pulses, q);
  endtask

  task automatic test_long_shamt();
    int busy_cycles;
    int guard;
    op(3'b011, 8'h01);
    start = 1'b1; select = 3'b101; shamt = CW'(9);
    busy_cycles = 0; guard = 0;
    tick();
    start = 1'b0;
    while (busy === 1'b1 && guard < 20) begin
      busy_cycles++; guard++;
      tick();
    end
    checks++;
    if (busy_cycles != 9 || q !== 8'h02 || done !== 1'b1) begin
      errors++; $display("FAIL rotl9: cycles=%0d q=%h done=%b required 9 02 1", busy_cycles, q, done);
    end
    op(3'b111, 8'h00);
    ser_r_in = 1'b1;
    start = 1'b1; select = 3'b001; shamt = CW'(10);
    guard = 0;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && guard < 20) begin
      guard++;
      tick();
    end
    ser_r_in = 1'b0;
    checks++;
    if (q !== 8'hFF || guard != 10) begin
      errors++; $display("FAIL shr10_saturate: q=%h steps=%0d required ff 10", q, guard);
    end
    $display("long shamt: q=%h", q);
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    op(3'b011, 8'h01);
    ser_l_in = 1'b0;
    start = 1'b1; select = 3'b010; shamt = CW'(6);
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (q !== 8'h04 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre: q=%h busy=%b required 04 1", q, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: q=%h busy=%b done=%b required 00 0 0", q, busy, done);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_no_done: bad_cycles=%0d required 0", bad);
    end
    $display("async reset abort: q=%h busy=%b done=%b", q, busy, done);
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_shift();
    test_rotate_asr_clear();
    test_seq();
    test_trivial_start();
    test_back_to_back();
    test_busy_ignore();
    test_long_shamt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
